// File: rtl/moxie_ifetch_wb.sv
// Moxie instruction fetch: Wishbone master filling a halfword queue, 16/48-bit length decode, valid/stall output.
// Define MOXIE_IFETCH_PERF_EN to add starve_count_o, a saturating count of cycles with no valid instruction.
module moxie_ifetch_wb #(
    parameter logic [31:0] RESET_VECTOR = 32'h00001000,
    parameter int          QDEPTH       = 6
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] wb_I_adr_o,
    output logic        wb_I_cyc_o,
    output logic        wb_I_stb_o,
    output logic        wb_I_we_o,
    input  logic [31:0] wb_I_dat_i,
    input  logic        wb_I_ack_i,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic [15:0] opcode_o,
    output logic [31:0] operand_o,
    output logic        valid_o
`ifdef MOXIE_IFETCH_PERF_EN
    ,
    output logic [31:0] starve_count_o
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t      state, state_next;
    logic [29:0] adr, adr_next, target, target_next;
    logic        drop, drop_next;
    logic [3:0]  count, count_next, remain, pop, push, free_now, free_after;
    logic [15:0] q   [QDEPTH];
    logic [15:0] ext [16];
    logic [15:0] nxt [16];
    logic        head_long, valid, consume, accept;
    logic        unused_bits;

    function automatic logic is_long(input logic [15:0] h);
        if (h[15]) return 1'b0;
        case (h[15:8])
            8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h1A, 8'h1B, 8'h1D,
            8'h1F, 8'h20, 8'h22, 8'h24, 8'h36, 8'h37, 8'h38, 8'h39: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign unused_bits = branch_target_i[0];

    assign head_long  = is_long(q[0]);
    assign valid      = count >= (head_long ? 4'd3 : 4'd1);
    assign consume    = valid && !stall_i && !branch_flag_i;
    assign accept     = (state == REQ) && wb_I_ack_i && !branch_flag_i;
    assign pop        = consume ? (head_long ? 4'd3 : 4'd1) : 4'd0;
    assign push       = accept ? (drop ? 4'd1 : 4'd2) : 4'd0;
    assign remain     = count - pop;
    assign free_now   = 4'(QDEPTH) - remain;
    assign free_after = free_now - push;
    assign count_next = branch_flag_i ? 4'd0 : remain + push;

    assign valid_o    = valid;
    assign opcode_o   = valid ? q[0] : 16'h0;
    assign operand_o  = (valid && head_long) ? {q[1], q[2]} : 32'h0;
    assign wb_I_adr_o = {adr, 2'b00};
    assign wb_I_cyc_o = (state != IDLE);
    assign wb_I_stb_o = (state != IDLE);
    assign wb_I_we_o  = 1'b0;

    // Queue update: shift out the popped halfwords, then append this cycle's push at the new tail.
    always_comb begin
        for (int i = 0; i < 16; i++) ext[i] = 16'h0;
        for (int i = 0; i < QDEPTH; i++) ext[i] = q[i];
        for (int i = 0; i < 16; i++) nxt[i] = ext[4'(i) + pop];
        if (accept) begin
            if (drop) begin
                nxt[remain] = wb_I_dat_i[15:0];
            end else begin
                nxt[remain]        = wb_I_dat_i[31:16];
                nxt[remain + 4'd1] = wb_I_dat_i[15:0];
            end
        end
    end

    always_comb begin
        state_next  = state;
        adr_next    = adr;
        target_next = target;
        drop_next   = drop;
        if (branch_flag_i) begin
            drop_next = branch_target_i[1];
            // An unacknowledged cycle must still complete at its old address before redirecting.
            if (state != IDLE && !wb_I_ack_i) begin
                state_next  = DISCARD;
                target_next = branch_target_i[31:2];
            end else begin
                state_next = REQ;
                adr_next   = branch_target_i[31:2];
            end
        end else begin
            unique case (state)
                IDLE: if (free_now >= 4'd2) state_next = REQ;
                REQ: begin
                    if (wb_I_ack_i) begin
                        adr_next   = adr + 30'd1;
                        drop_next  = 1'b0;
                        state_next = (free_after >= 4'd2) ? REQ : IDLE;
                    end
                end
                DISCARD: begin
                    if (wb_I_ack_i) begin
                        adr_next   = target;
                        state_next = REQ;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            adr    <= RESET_VECTOR[31:2];
            target <= 30'h0;
            drop   <= RESET_VECTOR[1];
            count  <= 4'd0;
        end else begin
            state  <= state_next;
            adr    <= adr_next;
            target <= target_next;
            drop   <= drop_next;
            count  <= count_next;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < QDEPTH; i++) q[i] <= nxt[i];
    end

`ifdef MOXIE_IFETCH_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) starve_count_o <= 32'h0;
        else if (!valid) starve_count_o <= sat_inc(starve_count_o);
    end
`endif

endmodule

// File: tb/tb_moxie_ifetch_wb.sv
// Bench for moxie_ifetch_wb: directed fetch/branch/reset sequences, a decode vector table and a random run
// checked against an instruction-level model that walks memory from the program counter.
module tb_moxie_ifetch_wb;
    localparam logic [31:0] RV = 32'h0000_1000;

    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] adr, dat = 32'h0, tgt = 32'h0, opnd;
    logic        cyc, stb, we, ack = 1'b0, stall = 1'b0, br = 1'b0, vld;
    logic [15:0] op;
`ifdef MOXIE_IFETCH_PERF_EN
    logic [31:0] starve;
`endif

    int n_cmp = 0, n_bad = 0, n_consume = 0;
    logic [31:0] memov [logic [31:0]];
    logic [31:0] ack_log [$];
    bit ack_en = 1'b0, ack_rand = 1'b0;
    int ack_wait = 0;

    typedef struct {
        logic [31:0] tgt;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [15:0] op;
        logic [31:0] opnd;
    } vec_t;
    vec_t tab [8];

    moxie_ifetch_wb #(.RESET_VECTOR(RV), .QDEPTH(6)) dut (
        .clk_i(clk), .rst_i(rst),
        .wb_I_adr_o(adr), .wb_I_cyc_o(cyc), .wb_I_stb_o(stb), .wb_I_we_o(we),
        .wb_I_dat_i(dat), .wb_I_ack_i(ack),
        .stall_i(stall), .branch_flag_i(br), .branch_target_i(tgt),
        .opcode_o(op), .operand_o(opnd), .valid_o(vld)
`ifdef MOXIE_IFETCH_PERF_EN
        , .starve_count_o(starve)
`endif
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w = {a[31:2], 2'b00};
        logic [31:0] h;
        if (memov.exists(w)) return memov[w];
        h = (w * 32'h9E37_79B1) ^ {w[15:0], w[31:16]} ^ 32'h0F0F_3C00;
        if (h[2:0] == 3'd0) h[31:24] = 8'h01;
        if (h[5:3] == 3'd0) h[15:8] = 8'h39;
        return h;
    endfunction

    function automatic logic [15:0] mem_half(input logic [31:0] a);
        logic [31:0] w = mem_word(a);
        return a[1] ? w[15:0] : w[31:16];
    endfunction

    function automatic bit long48(input logic [15:0] h);
        return h[15:8] inside {8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h1A, 8'h1B, 8'h1D,
                               8'h1F, 8'h20, 8'h22, 8'h24, 8'h36, 8'h37, 8'h38, 8'h39};
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int k = 0;
        while (!vld && k < budget) begin
            tick();
            k++;
        end
        if (!vld) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_cyc(input string name, input int budget);
        int k = 0;
        tick();
        while (!cyc && k < budget) begin
            tick();
            k++;
        end
        if (!cyc) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Wishbone slave: answers from mem_word, checks bus-side rules every cycle.
    initial begin
        logic [31:0] prev_adr;
        bit prev_cyc, prev_ack;
        int wcnt;
        prev_adr = 32'h0; prev_cyc = 1'b0; prev_ack = 1'b0; wcnt = 0;
        forever begin
            @(negedge clk);
            if (cyc) begin
                check("stb_eq_cyc", {31'h0, stb}, 32'd1);
                check("we_zero", {31'h0, we}, 32'd0);
                check("adr_align", {30'h0, adr[1:0]}, 32'd0);
                if (prev_cyc && !prev_ack) begin
                    check("adr_stable", adr, prev_adr);
                    wcnt++;
                end else begin
                    wcnt = 0;
                end
            end
            ack = cyc && ack_en && (wcnt >= ack_wait) && (!ack_rand || $urandom_range(0, 2) != 0);
            dat = ack ? mem_word(adr) : 32'hDEAD_BEEF;
            if (ack) ack_log.push_back(adr);
            prev_cyc = cyc; prev_ack = ack; prev_adr = adr;
        end
    end

    // Instruction-level reference: whatever is valid must be the instruction at pc.
    initial begin
        logic [31:0] pc;
        logic [15:0] h;
        pc = RV;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                pc = RV;
            end else if (br) begin
                pc = {tgt[31:1], 1'b0};
            end else if (vld) begin
                h = mem_half(pc);
                check("model_opcode", {16'h0, op}, {16'h0, h});
                check("model_operand", opnd, long48(h) ? {mem_half(pc + 32'd2), mem_half(pc + 32'd4)} : 32'h0);
                if (!stall) begin
                    pc = pc + (long48(h) ? 32'd6 : 32'd2);
                    n_consume++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int nl;
        tab[0] = '{32'h4000, 32'h0100_ABCD, 32'hEF01_2345, 16'h0100, 32'hABCD_EF01};
        tab[1] = '{32'h4012, 32'hFFFF_3612, 32'h3456_789A, 16'h3612, 32'h3456_789A};
        tab[2] = '{32'h4020, 32'h8D00_1111, 32'h0000_0000, 16'h8D00, 32'h0000_0000};
        tab[3] = '{32'h4030, 32'h0200_5555, 32'h0000_0000, 16'h0200, 32'h0000_0000};
        tab[4] = '{32'h4042, 32'h0000_3902, 32'hCAFE_BABE, 16'h3902, 32'hCAFE_BABE};
        tab[5] = '{32'h4050, 32'h1F00_0000, 32'h1234_5678, 16'h1F00, 32'h0000_1234};
        tab[6] = '{32'h4060, 32'h2300_0101, 32'h0000_0000, 16'h2300, 32'h0000_0000};
        tab[7] = '{32'h4073, 32'h0000_0C00, 32'h1111_2222, 16'h0C00, 32'h1111_2222};
        for (int i = 0; i < 8; i++) begin
            a = {tab[i].tgt[31:2], 2'b00};
            memov[a] = tab[i].w0;
            memov[a + 32'd4] = tab[i].w1;
        end
        memov[32'h1000] = 32'h0100_0000;
        memov[32'h1004] = 32'h1234_2600;
        memov[32'h2000] = 32'hAAAA_0515;
        memov[32'h2004] = 32'h2600_2600;
        memov[32'h3000] = 32'h2600_0515;

        repeat (3) tick();
        check("rst_cyc", {31'h0, cyc}, 32'd0);
        check("rst_stb", {31'h0, stb}, 32'd0);
        check("rst_adr", adr, 32'h1000);
        check("rst_valid", {31'h0, vld}, 32'd0);
        check("rst_opcode", {16'h0, op}, 32'd0);
        check("rst_operand", opnd, 32'd0);

        // Reset-vector fetch with zero-wait acks.
        ack_en = 1'b1; ack_wait = 0; ack_rand = 1'b0; rst = 1'b0;
        tick();
        check("rv_cyc", {31'h0, cyc}, 32'd1);
        check("rv_adr0", adr, 32'h1000);
        check("rv_valid_lo0", {31'h0, vld}, 32'd0);
        tick();
        check("rv_adr1", adr, 32'h1004);
        check("rv_valid_lo1", {31'h0, vld}, 32'd0);
        tick();
        check("rv_valid", {31'h0, vld}, 32'd1);
        check("rv_opcode", {16'h0, op}, 32'h0100);
        check("rv_operand", opnd, 32'h0000_1234);
        tick();
        check("rv2_opcode", {16'h0, op}, 32'h2600);
        check("rv2_operand", opnd, 32'd0);
        check("rv_log0", ack_log[0], 32'h1000);
        check("rv_log1", ack_log[1], 32'h1004);

        // Stall hold: outputs frozen, bus goes idle once the queue is full.
        stall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("stall_opcode", {16'h0, op}, 32'h2600);
            check("stall_valid", {31'h0, vld}, 32'd1);
        end
        check("stall_cyc_drop", {31'h0, cyc}, 32'd0);
        nl = ack_log.size();
        repeat (3) tick();
        check("stall_no_req", ack_log.size(), nl);
        stall = 1'b0;
        repeat (4) tick();

        // Branch to an odd halfword.
        br = 1'b1; tgt = 32'h2002;
        tick();
        br = 1'b0;
        check("odd_valid_lo", {31'h0, vld}, 32'd0);
        check("odd_adr", adr, 32'h2000);
        check("odd_cyc", {31'h0, cyc}, 32'd1);
        wait_valid("odd", 20);
        check("odd_opcode", {16'h0, op}, 32'h0515);

        // Branch while a transfer is pending and ack is withheld.
        ack_en = 1'b0;
        wait_cyc("pend", 30);
        a = adr;
        br = 1'b1; tgt = 32'h3000;
        tick();
        br = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("pend_cyc", {31'h0, cyc}, 32'd1);
            check("pend_old_adr", adr, a);
            check("pend_valid_lo", {31'h0, vld}, 32'd0);
            if (i < 2) tick();
        end
        ack_en = 1'b1;
        tick();
        check("pend_ack_adr", adr, a);
        check("pend_discard_valid", {31'h0, vld}, 32'd0);
        tick();
        check("pend_new_adr", adr, 32'h3000);
        check("pend_log_new", ack_log[ack_log.size() - 1], 32'h3000);
        check("pend_log_old", ack_log[ack_log.size() - 2], a);
        tick();
        check("pend_first_valid", {31'h0, vld}, 32'd1);
        check("pend_first_opcode", {16'h0, op}, 32'h2600);

        // Reset during a request with ack on the same edge.
        ack_en = 1'b0;
        wait_cyc("rstmid", 30);
        ack_en = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        check("rstmid_cyc", {31'h0, cyc}, 32'd0);
        check("rstmid_valid", {31'h0, vld}, 32'd0);
        check("rstmid_opcode", {16'h0, op}, 32'd0);
        check("rstmid_adr", adr, 32'h1000);
        rst = 1'b0;
        tick();
        check("rstmid_refetch_cyc", {31'h0, cyc}, 32'd1);
        check("rstmid_refetch_adr", adr, 32'h1000);

        // Decode vector table, reached by branches with random ack timing.
        ack_rand = 1'b1;
        for (int i = 0; i < 8; i++) begin
            br = 1'b1; tgt = tab[i].tgt;
            tick();
            br = 1'b0;
            wait_valid("tab", 40);
            check("tab_opcode", {16'h0, op}, {16'h0, tab[i].op});
            check("tab_operand", opnd, tab[i].opnd);
        end

        // Random run: stalls, branches (including one near the top of memory) and random ack timing.
        nl = n_consume;
        for (int i = 0; i < 3000; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else tgt = 32'h8000 + 32'($urandom_range(0, 16'hFFF));
            tick();
        end
        stall = 1'b0; br = 1'b0;
        tick();
        check("rand_progress", {31'h0, (n_consume - nl) > 200}, 32'd1);

`ifdef MOXIE_IFETCH_PERF_EN
        rst = 1'b1; ack_rand = 1'b0; ack_wait = 1;
        memov[32'h1000] = 32'h2600_2600;
        repeat (2) tick();
        rst = 1'b0;
        wait_valid("perf", 20);
        check("perf_starve", starve, 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
